// File: rtl/snake_tile_renderer_pkg.sv
// Shared definitions for the snake tile renderer and the game logic that feeds it.
// Holds tile codes, map geometry, default colours, the write-port state type and
// the tile index helper (row * 40 + column built from shifts).
package snake_tile_renderer_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'b00,
    TILE_BODY  = 2'b01,
    TILE_HEAD  = 2'b10,
    TILE_FOOD  = 2'b11
  } tile_code_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } wr_state_e;

  localparam logic [5:0]  MAP_COLS   = 6'd40;
  localparam logic [4:0]  MAP_ROWS   = 5'd30;
  localparam logic [10:0] MAP_DEPTH  = 11'd1200;
  localparam logic [10:0] MAP_LAST   = MAP_DEPTH - 11'd1;
  localparam int          TILE_SHIFT = 4;

  localparam logic [7:0] DEF_BG_COLOUR   = 8'h00;
  localparam logic [7:0] DEF_BODY_COLOUR = 8'h1C;
  localparam logic [7:0] DEF_HEAD_COLOUR = 8'hFC;
  localparam logic [7:0] DEF_FOOD_COLOUR = 8'hE0;

  // y*40 + x as (y<<5) + (y<<3) + x, no multiplier needed
  function automatic logic [10:0] tile_index(input logic [4:0] y, input logic [5:0] x);
    logic [10:0] yw;
    yw = {6'd0, y};
    return (yw << 5) + (yw << 3) + {5'd0, x};
  endfunction

endpackage

// File: rtl/snake_tile_renderer_if.sv
// Tile write / clear bus between game logic (master) and the renderer (slave).
//   TILE_WE/TILE_X/TILE_Y/TILE_DATA : single-cycle tile write request
//   TILE_ACK / TILE_ERR             : one-cycle commit / drop pulses
//   CLEAR_REQ / BUSY                : map clear request and sweep-in-progress flag
interface snake_tile_renderer_if;
  logic       TILE_WE;
  logic [5:0] TILE_X;
  logic [4:0] TILE_Y;
  logic [1:0] TILE_DATA;
  logic       TILE_ACK;
  logic       TILE_ERR;
  logic       CLEAR_REQ;
  logic       BUSY;

  modport master (
    output TILE_WE, TILE_X, TILE_Y, TILE_DATA, CLEAR_REQ,
    input  TILE_ACK, TILE_ERR, BUSY
  );

  modport slave (
    input  TILE_WE, TILE_X, TILE_Y, TILE_DATA, CLEAR_REQ,
    output TILE_ACK, TILE_ERR, BUSY
  );
endinterface

// File: rtl/snake_tile_ram.sv
// 1200 x 2-bit simple dual-port tile map, written so it maps onto block RAM.
//   CLK           : clock
//   WE/WADDR/WDATA: write port
//   RADDR/RDATA   : synchronous read port, read-first on an address collision
module snake_tile_ram
  import snake_tile_renderer_pkg::*;
(
  input  logic        CLK,
  input  logic        WE,
  input  logic [10:0] WADDR,
  input  logic [1:0]  WDATA,
  input  logic [10:0] RADDR,
  output logic [1:0]  RDATA
);

  logic [1:0] mem [0:MAP_DEPTH-1];

  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
    RDATA <= mem[RADDR];
  end

endmodule

// File: rtl/snake_tile_renderer.sv
// Pixel source for the VGA timing block. Renders a 40x30 map of 16x16 tiles with
// grid gaps and a frame-counted food blink; two-cycle latency from ADDRH/ADDRV to
// COLOUR_OUT. Game logic writes tiles and requests clears over the tile interface.
//   CLK, RESET  : pixel clock, async active-high reset
//   ADDRH/ADDRV : visible pixel address
//   COLOUR_OUT  : RRRGGGBB colour, pixel addressed two cycles earlier
//   FRAME_TICK  : one pulse after the last visible pixel of each frame
//   tile        : tile write / clear bus (slave side)
//
//   state    | meaning
//   ST_CLEAR | sweeping code 00 into every map entry, one per cycle
//   ST_IDLE  | accepting tile writes and clear requests
module snake_tile_renderer
  import snake_tile_renderer_pkg::*;
#(
  parameter logic [7:0] BG_COLOUR   = DEF_BG_COLOUR,
  parameter logic [7:0] BODY_COLOUR = DEF_BODY_COLOUR,
  parameter logic [7:0] HEAD_COLOUR = DEF_HEAD_COLOUR,
  parameter logic [7:0] FOOD_COLOUR = DEF_FOOD_COLOUR,
  parameter int         BLINK_BIT   = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [9:0]                  ADDRH,
  input  logic [8:0]                  ADDRV,
  output logic [7:0]                  COLOUR_OUT,
  output logic                        FRAME_TICK,
  snake_tile_renderer_if.slave        tile
);

  wr_state_e   state, state_nxt;
  logic [10:0] clr_idx, clr_idx_nxt;
  logic        ack_q, ack_nxt, err_q, err_nxt;
  logic        ram_we;
  logic [10:0] ram_waddr, ram_raddr;
  logic [1:0]  ram_wdata, code_s1;
  logic [3:0]  lx_s1, ly_s1;
  logic [7:0]  colour_nxt, frame_cnt;
  logic        in_range, last_px, last_q;

  assign in_range  = (tile.TILE_X < MAP_COLS) && (tile.TILE_Y < MAP_ROWS);
  assign ram_raddr = tile_index(ADDRV[8:TILE_SHIFT], ADDRH[9:TILE_SHIFT]);

  snake_tile_ram u_ram (
    .CLK   (CLK),
    .WE    (ram_we),
    .WADDR (ram_waddr),
    .WDATA (ram_wdata),
    .RADDR (ram_raddr),
    .RDATA (code_s1)
  );

  // Write port FSM
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      ack_q   <= ack_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ack_nxt     = 1'b0;
    err_nxt     = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = tile_index(tile.TILE_Y, tile.TILE_X);
    ram_wdata   = tile.TILE_DATA;
    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx;
        ram_wdata = TILE_EMPTY;
        err_nxt   = tile.TILE_WE;
        if (clr_idx == MAP_LAST) begin
          state_nxt   = ST_IDLE;
          clr_idx_nxt = '0;
        end else begin
          clr_idx_nxt = clr_idx + 11'd1;
        end
      end
      default: begin
        if (tile.TILE_WE) begin
          if (in_range) begin
            ram_we  = 1'b1;
            ack_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        // a simultaneous write still commits; the sweep then overwrites it
        if (tile.CLEAR_REQ) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = '0;
        end
      end
    endcase
  end

  assign tile.TILE_ACK = ack_q;
  assign tile.TILE_ERR = err_q;
  assign tile.BUSY     = (state == ST_CLEAR);

  // Render pipeline: stage 1 is the RAM read plus local bits, stage 2 the colour
  always_comb begin
    colour_nxt = BG_COLOUR;
    if (lx_s1 != 4'hF && ly_s1 != 4'hF) begin
      case (tile_code_e'(code_s1))
        TILE_BODY: colour_nxt = BODY_COLOUR;
        TILE_HEAD: colour_nxt = HEAD_COLOUR;
        TILE_FOOD: if (!frame_cnt[BLINK_BIT]) colour_nxt = FOOD_COLOUR;
        default:   colour_nxt = BG_COLOUR;
      endcase
    end
  end

  assign last_px = (ADDRH == 10'd639) && (ADDRV == 9'd479);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lx_s1      <= '0;
      ly_s1      <= '0;
      COLOUR_OUT <= '0;
      last_q     <= 1'b0;
      FRAME_TICK <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      lx_s1      <= ADDRH[3:0];
      ly_s1      <= ADDRV[3:0];
      COLOUR_OUT <= colour_nxt;
      last_q     <= last_px;
      FRAME_TICK <= last_px & ~last_q;
      if (FRAME_TICK) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
